// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing helpers for the shift-add multiplier controller
package mult_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  localparam int CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/mult_iter_counter.sv
// rtl/mult_iter_counter.sv - iteration counter with clear, enable and last-count flag
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Exit compares at WIDTH-1, so the counter never wraps inside an operation.
  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_controller.sv
// rtl/mult_seq_controller.sv - shift-add multiplier sequencer; MULT_ZERO_BYPASS_EN skips RUN for zero operands
module mult_seq_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] multiplicand_in,
  input  logic [WIDTH-1:0] multiplier_in,
  input  logic             prod_lsb,
  output logic [WIDTH-1:0] prod_init_data,
  output logic             prod_init_wr,
  output logic             prod_wr,
  output logic             prod_sh_right,
  output logic [WIDTH-1:0] mcand_out,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] mcand_q;
  logic             accept;
  logic             cnt_last;

  assign accept = (state_q == IDLE) && start_valid;

`ifdef MULT_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (multiplicand_in == '0) || (multiplier_in == '0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q <= multiplicand_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
`ifdef MULT_ZERO_BYPASS_EN
          state_d = zero_op ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The product register LSB selects add-and-shift versus plain shift each RUN cycle.
  always_comb begin
    start_ready    = (state_q == IDLE);
    busy           = (state_q == RUN);
    result_valid   = (state_q == DONE);
    prod_init_wr   = accept;
    prod_wr        = (state_q == RUN) && prod_lsb;
    prod_sh_right  = (state_q == RUN) && !prod_lsb;
`ifdef MULT_ZERO_BYPASS_EN
    prod_init_data = (start_valid && zero_op) ? '0 : multiplier_in;
`else
    prod_init_data = multiplier_in;
`endif
  end

  assign mcand_out = mcand_q;

  mult_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (state_q == RUN),
    .last    (cnt_last)
  );

endmodule
